// File: rtl/gcd_pkg.sv
//==============================================================================
//  Module      : gcd_pkg
//  Description : Shared types and constants for the GCD job dispatcher:
//                operand width, job record and dispatcher FSM states.
//  Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

package gcd_pkg;

    localparam int OPER_W    = 32;
    localparam int TAG_MAX_W = 16;
    localparam int CYC_W     = 16;

    typedef logic [TAG_MAX_W-1:0] tag_t;

    // One queued job; the tag field is sized for the widest tag supported.
    typedef struct packed {
        logic [OPER_W-1:0] u;
        logic [OPER_W-1:0] v;
        tag_t              tag;
    } job_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ARM  = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/gcd_dispatch_if.sv
//==============================================================================
//  Module      : gcd_dispatch_if
//  Description : Job input, engine and result channels of the GCD dispatcher.
//                slave = dispatcher side, master = environment side.
//  Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

interface gcd_dispatch_if #(
    parameter int TAG_W = 4
);
    import gcd_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [OPER_W-1:0]    in_u;
    logic [OPER_W-1:0]    in_v;
    logic [TAG_W-1:0]     in_tag;

    logic                 eng_load;
    logic [OPER_W-1:0]    eng_u;
    logic [OPER_W-1:0]    eng_v;
    logic [OPER_W-1:0]    eng_result;
    logic                 eng_busy;

    logic                 out_valid;
    logic                 out_ready;
    logic [OPER_W-1:0]    out_result;
    logic [TAG_W-1:0]     out_tag;
    logic [CYC_W-1:0]     out_cycles;

    modport slave (
        input  in_valid, in_u, in_v, in_tag, eng_result, eng_busy, out_ready,
        output in_ready, eng_load, eng_u, eng_v, out_valid, out_result, out_tag, out_cycles
    );

    modport master (
        output in_valid, in_u, in_v, in_tag, eng_result, eng_busy, out_ready,
        input  in_ready, eng_load, eng_u, eng_v, out_valid, out_result, out_tag, out_cycles
    );

endinterface

`default_nettype wire

// File: rtl/gcd_job_fifo.sv
//==============================================================================
//  Module      : gcd_job_fifo
//  Description : Show-ahead synchronous FIFO; head entry visible on pop_data.
//                DEPTH must be a power of two so pointers wrap naturally.
//  Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module gcd_job_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap modulo DEPTH; count tracks occupancy including simultaneous push/pop.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/gcd_dispatch.sv
//==============================================================================
//  Module      : gcd_dispatch
//  Description : Queues GCD jobs, feeds them one at a time to an external
//                engine and returns result, tag and engine cycle count in
//                acceptance order.
//  Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module gcd_dispatch
    import gcd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic          clk,
    input  logic          reset_l,
    gcd_dispatch_if.slave bus
);

    state_t              state;
    state_t              state_nxt;
    job_t                push_job;
    job_t                head_job;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                eng_load;
    logic                out_valid;
    logic [OPER_W-1:0]   eng_u_r;
    logic [OPER_W-1:0]   eng_v_r;
    logic [TAG_W-1:0]    tag_r;
    logic [OPER_W-1:0]   result_r;
    logic [CYC_W-1:0]    cycles_r;

    assign push = bus.in_valid && !fifo_full;

    // Widen the incoming tag into the package job record.
    always_comb begin
        push_job.u   = bus.in_u;
        push_job.v   = bus.in_v;
        push_job.tag = tag_t'(bus.in_tag);
    end

    gcd_job_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(job_t))
    ) u_fifo (
        .clk       (clk),
        .reset_l   (reset_l),
        .push      (push),
        .push_data (push_job),
        .pop       (pop),
        .pop_data  (head_job),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Upper tag bits of the stored record are always zero for narrow tags.
    if (TAG_W < TAG_MAX_W) begin : g_tag_pad
        logic tag_pad_unused;
        assign tag_pad_unused = &{1'b0, head_job.tag[TAG_MAX_W-1:TAG_W]};
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // FSM next state; ARM skips the busy flag left over from the previous job.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (!fifo_empty)   state_nxt = ST_LOAD;
            ST_LOAD:                    state_nxt = ST_ARM;
            ST_ARM:                     state_nxt = ST_WAIT;
            ST_WAIT: if (!bus.eng_busy) state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: pop in IDLE, load pulse in LOAD, result valid in DONE.
    always_comb begin
        pop       = (state == ST_IDLE) && !fifo_empty;
        eng_load  = (state == ST_LOAD);
        out_valid = (state == ST_DONE);
    end

    // Job operands, result capture and saturating engine cycle counter.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            eng_u_r  <= '0;
            eng_v_r  <= '0;
            tag_r    <= '0;
            result_r <= '0;
            cycles_r <= '0;
        end else begin
            if (pop) begin
                eng_u_r <= head_job.u;
                eng_v_r <= head_job.v;
                tag_r   <= head_job.tag[TAG_W-1:0];
            end
            if (state == ST_LOAD) begin
                cycles_r <= '0;
            end else if ((state == ST_ARM || state == ST_WAIT) && cycles_r != '1) begin
                cycles_r <= cycles_r + CYC_W'(1);
            end
            if (state == ST_WAIT && !bus.eng_busy) begin
                result_r <= bus.eng_result;
            end
        end
    end

    assign bus.in_ready   = !fifo_full;
    assign bus.eng_load   = eng_load;
    assign bus.eng_u      = eng_u_r;
    assign bus.eng_v      = eng_v_r;
    assign bus.out_valid  = out_valid;
    assign bus.out_result = result_r;
    assign bus.out_tag    = tag_r;
    assign bus.out_cycles = cycles_r;

endmodule

`default_nettype wire

// File: tb/tb_gcd_dispatch.sv
//==============================================================================
//  Module      : tb_gcd_dispatch
//  Description : Directed bench for gcd_dispatch with a behavioural GCD
//                engine whose busy time is set per test.
//  Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_gcd_dispatch;

    logic clk = 1'b0;
    logic reset_l = 1'b0;

    gcd_dispatch_if #(.TAG_W(4)) bus ();

    gcd_dispatch #(.FIFO_DEPTH(4), .TAG_W(4)) dut (
        .clk     (clk),
        .reset_l (reset_l),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] gcd_ref(input logic [31:0] a_in, input logic [31:0] b_in);
        logic [31:0] a = a_in;
        logic [31:0] b = b_in;
        logic [31:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Engine model: busy for lat cycles starting the cycle after the load pulse.
    int unsigned lat = 5;
    int unsigned rem;
    bit          ld_seen;
    logic [31:0] ld_u;
    logic [31:0] ld_v;

    always @(negedge clk) begin
        ld_seen = bus.eng_load;
        ld_u    = bus.eng_u;
        ld_v    = bus.eng_v;
    end

    always @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            bus.eng_busy   <= 1'b0;
            bus.eng_result <= '0;
            rem            <= 0;
        end else if (ld_seen) begin
            bus.eng_busy   <= 1'b1;
            bus.eng_result <= gcd_ref(ld_u, ld_v);
            rem            <= lat;
        end else if (bus.eng_busy) begin
            if (rem <= 1) bus.eng_busy <= 1'b0;
            else          rem <= rem - 1;
        end
    end

    // Result and load-pulse monitor, sampled mid-cycle.
    int          load_cnt = 0;
    logic [31:0] res_q [$];
    logic [3:0]  tag_q [$];
    logic [15:0] cyc_q [$];

    always @(negedge clk) begin
        if (bus.eng_load) load_cnt++;
        if (bus.out_valid && bus.out_ready) begin
            res_q.push_back(bus.out_result);
            tag_q.push_back(bus.out_tag);
            cyc_q.push_back(bus.out_cycles);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_job(input logic [31:0] u, input logic [31:0] v, input logic [3:0] tag);
        bit acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_u     = u;
        bus.in_v     = v;
        bus.in_tag   = tag;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = bus.in_ready;
            tick();
        end
        bus.in_valid = 1'b0;
        check("push_accept", 32'(acc), 1);
    endtask

    task automatic wait_results(input int n, input int budget);
        int k = 0;
        while (res_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check("result_count", res_q.size(), n);
    endtask

    task automatic check_result(input int i, input logic [31:0] r, input logic [3:0] t, input logic [15:0] c);
        if (i < res_q.size()) begin
            check($sformatf("result[%0d]", i), res_q[i], r);
            check($sformatf("tag[%0d]", i), 32'(tag_q[i]), 32'(t));
            check($sformatf("cycles[%0d]", i), 32'(cyc_q[i]), 32'(c));
        end else begin
            check($sformatf("present[%0d]", i), 0, 1);
        end
    endtask

    task automatic clear_results();
        res_q.delete();
        tag_q.delete();
        cyc_q.delete();
    endtask

    logic [31:0] seq_u   [5] = '{32'd12, 32'd7, 32'd100, 32'd9, 32'd21};
    logic [31:0] seq_v   [5] = '{32'd8,  32'd5, 32'd75,  32'd9, 32'd14};
    logic [31:0] seq_exp [5] = '{32'd4,  32'd1, 32'd25,  32'd9, 32'd7};
    logic [31:0] z_u     [3] = '{32'd0, 32'd5, 32'd0};
    logic [31:0] z_v     [3] = '{32'd5, 32'd0, 32'd0};
    logic [31:0] z_exp   [3] = '{32'd5, 32'd5, 32'd0};

    initial begin
        int l0;
        int k;
        bus.in_valid  = 1'b0;
        bus.in_u      = '0;
        bus.in_v      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",   32'(bus.in_ready), 1);
        check("rst_out_valid",  32'(bus.out_valid), 0);
        check("rst_eng_load",   32'(bus.eng_load), 0);
        check("rst_eng_u",      bus.eng_u, 0);
        check("rst_eng_v",      bus.eng_v, 0);
        check("rst_out_result", bus.out_result, 0);
        check("rst_out_tag",    32'(bus.out_tag), 0);
        check("rst_out_cycles", 32'(bus.out_cycles), 0);
        tick();
        reset_l = 1'b1;
        tick();

        // Single job: 48,18 -> 6; busy 5 cycles gives ARM + 5 WAIT = 6 counted cycles
        lat = 5;
        bus.out_ready = 1'b1;
        l0 = load_cnt;
        push_job(32'd48, 32'd18, 4'd3);
        wait_results(1, 100);
        check_result(0, 32'd6, 4'd3, 16'd6);
        repeat (5) tick();
        check("single_load_pulses", load_cnt - l0, 1);

        // Hold a result in DONE, fill the FIFO behind it, then drain in order
        clear_results();
        lat = 3;
        bus.out_ready = 1'b0;
        push_job(32'd30, 32'd12, 4'd15);
        k = 0;
        while (!bus.out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("hold_reached_done", 32'(bus.out_valid), 1);
        tick();
        l0 = load_cnt;
        for (int i = 0; i < 4; i++) push_job(seq_u[i], seq_v[i], 4'(i + 1));
        bus.in_valid = 1'b1;
        bus.in_u     = seq_u[4];
        bus.in_v     = seq_v[4];
        bus.in_tag   = 4'd5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("full_in_ready", 32'(bus.in_ready), 0);
            check("hold_valid",    32'(bus.out_valid), 1);
            check("hold_result",   bus.out_result, 6);
            check("hold_tag",      32'(bus.out_tag), 15);
            check("hold_cycles",   32'(bus.out_cycles), 4);
            tick();
        end
        check("hold_no_load", load_cnt - l0, 0);
        bus.out_ready = 1'b1;
        push_job(seq_u[4], seq_v[4], 4'd5);
        wait_results(6, 200);
        check_result(0, 32'd6, 4'd15, 16'd4);
        for (int i = 0; i < 5; i++) check_result(i + 1, seq_exp[i], 4'(i + 1), 16'd4);

        // Zero operands
        clear_results();
        lat = 2;
        for (int i = 0; i < 3; i++) push_job(z_u[i], z_v[i], 4'(i + 8));
        wait_results(3, 100);
        for (int i = 0; i < 3; i++) check_result(i, z_exp[i], 4'(i + 8), 16'd3);

        // Reset while the engine is busy with three jobs queued
        clear_results();
        lat = 50;
        push_job(32'd8, 32'd4, 4'd1);
        repeat (8) tick();
        push_job(32'd6, 32'd4, 4'd2);
        push_job(32'd9, 32'd3, 4'd3);
        push_job(32'd10, 32'd5, 4'd4);
        reset_l = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(bus.out_valid), 0);
        check("midrst_in_ready",  32'(bus.in_ready), 1);
        check("midrst_eng_load",  32'(bus.eng_load), 0);
        tick();
        tick();
        reset_l = 1'b1;
        l0 = load_cnt;
        repeat (80) tick();
        check("midrst_no_results", res_q.size(), 0);
        check("midrst_no_load",    load_cnt - l0, 0);

        // Long engine run saturates the cycle counter
        clear_results();
        lat = 70000;
        push_job(32'd1, 32'hFFFF_FFFF, 4'd9);
        wait_results(1, 71000);
        check_result(0, 32'd1, 4'd9, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
